alu_bist_driver: RTL

//   Built-in self-test initiator for the 32-bit ALU. It drives the ALU's operation and operand inputs from LFSRs.
//   It folds each result (data + zero flag) into a MISR and compares the final signature against a golden value.
//   It sits beside the ALU; bist_active_o steers the datapath operand/opcode muxes to this block during a run.

---
 rtl/alu_bist_driver_pkg.sv | 39 +++
 rtl/alu_bist_driver_if.sv | 11 +
 rtl/alu_bist_driver_lfsr32.sv | 32 +++
 rtl/alu_bist_driver.sv | 121 ++++++++++++
 4 files changed

// File: rtl/alu_bist_driver_pkg.sv
// Shared constants for the ALU BIST driver: ALU opcodes, LFSR taps, FSM states
// and the MISR fold used to compress each ALU result.
package alu_bist_driver_pkg;

   localparam logic [3:0]  OP_NOP = 4'b0000;
   localparam logic [3:0]  OP_ADD = 4'b0011;
   localparam logic [3:0]  OP_SUB = 4'b0100;
   localparam logic [3:0]  OP_OR  = 4'b0010;
   localparam logic [3:0]  OP_AND = 4'b0110;
   localparam logic [3:0]  OP_LUI = 4'b0101;

   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_CHECK = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic logic [3:0] op_of_idx(input logic [2:0] idx);
      case (idx)
         3'd0:    return OP_ADD;
         3'd1:    return OP_SUB;
         3'd2:    return OP_OR;
         3'd3:    return OP_AND;
         3'd4:    return OP_LUI;
         default: return OP_NOP;
      endcase
   endfunction

   // Feedback taps 31/21/1/0 shift into bit 0; the zero flag lands on bit 0 too.
   function automatic logic [31:0] misr_fold(input logic [31:0] misr,
                                             input logic [31:0] data,
                                             input logic        zero);
      return {misr[30:0], misr[31] ^ misr[21] ^ misr[1] ^ misr[0]} ^ data ^ {31'b0, zero};
   endfunction

endpackage

// File: rtl/alu_bist_driver_if.sv
// ALU stimulus/response bus between the BIST driver (master) and the ALU (slave).
interface alu_bist_driver_if;
   logic [3:0]  alu_operation;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] alu_data;
   logic        zero;

   modport master (output alu_operation, a, b, input alu_data, zero);
   modport slave  (input alu_operation, a, b, output alu_data, zero);
endinterface

// File: rtl/alu_bist_driver_lfsr32.sv
// 32-bit right-shifting Galois LFSR with synchronous seed load and step enable.
module alu_bist_driver_lfsr32
   import alu_bist_driver_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h0000_0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] seed_i,
   input  logic        load_i,
   input  logic        step_i,
   output logic [31:0] q_o
);

   logic [31:0] state_q, state_d;

   always_comb begin
      state_d = state_q;
      if (load_i)
         state_d = seed_i;
      else if (step_i)
         state_d = state_q[0] ? ((state_q >> 1) ^ LFSR_TAPS) : (state_q >> 1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= SEED;
      else       state_q <= state_d;
   end

   assign q_o = state_q;

endmodule

// File: rtl/alu_bist_driver.sv
// BIST initiator for the 32-bit ALU: LFSR operands, rotating opcodes, MISR
// compression of results and a final golden-signature compare.
module alu_bist_driver
   import alu_bist_driver_pkg::*;
#(
   parameter int          NUM_VECTORS = 256,
   parameter logic [31:0] SEED_A      = 32'hACE1_2345,
   parameter logic [31:0] SEED_B      = 32'h1357_9BDF,
   parameter logic [31:0] GOLDEN_SIG  = 32'h0000_0000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_i,
   alu_bist_driver_if.master   alu,
   output logic                bist_active_o,
   output logic                done_o,
   output logic                pass_o,
   output logic                zero_err_o,
   output logic [31:0]         signature_o
);

   localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

   state_t      state_q, state_d;
   logic [31:0] misr_q, misr_d;
   logic [31:0] sig_q, sig_d;
   logic [15:0] vec_cnt_q, vec_cnt_d;
   logic [2:0]  op_idx_q, op_idx_d;
   logic        zero_err_q, zero_err_d;
   logic        pass_q, pass_d;
   logic        lfsr_load, lfsr_step;
   logic [31:0] lfsr_a, lfsr_b;

   alu_bist_driver_lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
      .clk(clk), .reset(reset), .seed_i(SEED_A),
      .load_i(lfsr_load), .step_i(lfsr_step), .q_o(lfsr_a)
   );

   alu_bist_driver_lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
      .clk(clk), .reset(reset), .seed_i(SEED_B),
      .load_i(lfsr_load), .step_i(lfsr_step), .q_o(lfsr_b)
   );

   always_comb begin
      state_d    = state_q;
      misr_d     = misr_q;
      sig_d      = sig_q;
      vec_cnt_d  = vec_cnt_q;
      op_idx_d   = op_idx_q;
      zero_err_d = zero_err_q;
      pass_d     = pass_q;
      lfsr_load  = 1'b0;
      lfsr_step  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d    = ST_RUN;
               lfsr_load  = 1'b1;
               misr_d     = '0;
               sig_d      = '0;
               vec_cnt_d  = '0;
               op_idx_d   = '0;
               zero_err_d = 1'b0;
               pass_d     = 1'b0;
            end
         end
         // The ALU is combinational, so this edge captures the current vector.
         ST_RUN: begin
            lfsr_step = 1'b1;
            misr_d    = misr_fold(misr_q, alu.alu_data, alu.zero);
            if (alu.zero != (alu.alu_data == 32'd0))
               zero_err_d = 1'b1;
            op_idx_d  = (op_idx_q == 3'd4) ? 3'd0 : op_idx_q + 3'd1;
            vec_cnt_d = vec_cnt_q + 16'd1;
            if (vec_cnt_q == LAST_VEC)
               state_d = ST_CHECK;
         end
         ST_CHECK: begin
            pass_d  = (misr_q == GOLDEN_SIG) && !zero_err_q;
            sig_d   = misr_q;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (!start_i)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         misr_q     <= '0;
         sig_q      <= '0;
         vec_cnt_q  <= '0;
         op_idx_q   <= '0;
         zero_err_q <= 1'b0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         misr_q     <= misr_d;
         sig_q      <= sig_d;
         vec_cnt_q  <= vec_cnt_d;
         op_idx_q   <= op_idx_d;
         zero_err_q <= zero_err_d;
         pass_q     <= pass_d;
      end
   end

   // Outside RUN the ALU inputs are held at zero so the datapath idles quietly.
   assign bist_active_o     = (state_q == ST_RUN);
   assign done_o            = (state_q == ST_DONE);
   assign pass_o            = pass_q;
   assign zero_err_o        = zero_err_q;
   assign signature_o       = sig_q;
   assign alu.alu_operation = bist_active_o ? op_of_idx(op_idx_q) : OP_NOP;
   assign alu.a             = bist_active_o ? lfsr_a : 32'd0;
   assign alu.b             = bist_active_o ? lfsr_b : 32'd0;

endmodule
